// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters with a registered, source-tagged response
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  logic ptr_q, ptr_d, gnt_id, accept, hs, legal;
  logic [3:0] g_op;
  logic [XLEN-1:0] g_a, g_b;
  logic rsp_valid_q, rsp_valid_d, rsp_src_q, rsp_src_d, rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept     = !rsp_valid_q || rsp_ready;
    hs         = accept && (req0_valid || req1_valid);
    req0_ready = hs && !gnt_id;
    req1_ready = hs && gnt_id;
    g_op       = gnt_id ? req1_op : req0_op;
    g_a        = gnt_id ? req1_a : req0_a;
    g_b        = gnt_id ? req1_b : req0_b;
    legal      = g_op <= 4'd10;
    // idle or illegal requests park the ALU on a harmless ADD 0+0
    alu_op     = (hs && legal) ? g_op : 4'd3;
    alu_a      = (hs && legal) ? g_a : '0;
    alu_b      = (hs && legal) ? g_b : '0;
  end
  always_comb begin
    ptr_d        = hs ? !gnt_id : ptr_q;
    rsp_valid_d  = hs || (rsp_valid_q && !rsp_ready);
    rsp_src_d    = hs ? gnt_id : rsp_src_q;
    rsp_err_d    = hs ? !legal : rsp_err_q;
    rsp_result_d = hs ? (legal ? alu_result : '0) : rsp_result_q;
    cnt0_d       = (req0_ready && cnt0_q != '1) ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d       = (req1_ready && cnt1_q != '1) ? cnt1_q + CNT_W'(1) : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= RR_INIT != 0;
      rsp_valid_q  <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_src_q    <= rsp_src_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_src    = rsp_src_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_result = rsp_result_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with a response scoreboard; expected responses queued at handshake, popped by a monitor on consumption
module tb_alu_share_arbiter;
  logic clk = 1'b0, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [3:0] grant_cnt0, grant_cnt1;
  typedef struct packed {logic src; logic err; logic [31:0] res;} rsp_t;
  rsp_t sb[$];
  rsp_t mon_e;
  int vecs = 0, errs = 0;

  alu_share_arbiter #(.XLEN(32), .CNT_W(4), .RR_INIT(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a << b[4:0];
      4'd1: return a >> b[4:0];
      4'd2: return $signed(a) >>> b[4:0];
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a ^ b;
      4'd8: return {31'd0, $signed(a) < $signed(b)};
      4'd9: return {31'd0, a < b};
      4'd10: return b;
      default: return 32'hBAD0BAD0;
    endcase
  endfunction
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic rr, input logic [1:0] er, input logic [31:0] eres);
    logic [3:0] gop;
    logic lg;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
    #1;
    chk("ready", {62'd0, req1_ready, req0_ready}, {62'd0, er});
    gop = er[1] ? op1 : op0;
    lg = gop <= 4'd10;
    if (er != 2'b00) begin
      chk("alu_op", 64'(alu_op), lg ? 64'(gop) : 64'd3);
      chk("alu_a", 64'(alu_a), lg ? 64'(er[1] ? a1 : a0) : 64'd0);
      chk("alu_b", 64'(alu_b), lg ? 64'(er[1] ? b1 : b0) : 64'd0);
      sb.push_back('{src: er[1], err: !lg, res: eres});
    end else if (!v0 && !v1) begin
      chk("alu_idle", {28'd0, alu_op, alu_a}, {28'd0, 4'd3, 32'd0});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rr, 2'b00, 32'd0);
  endtask

  task automatic do_reset(input logic rr);
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = rr;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rsp_unexpected: got src=%0d res=%0h err=%0d expected none", rsp_src, rsp_result, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp", {31'd0, rsp_src, rsp_err, rsp_result}, {31'd0, mon_e.src, mon_e.err, mon_e.res});
      end
    end
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rsp", {60'd0, rsp_valid, rsp_src, rsp_err, |rsp_result}, 64'd0);
    chk("rst_cnt", {56'd0, grant_cnt0, grant_cnt1}, 64'd0);
    @(negedge clk);
    // single request
    step(1, 4'd3, 32'd5, 32'd7, 0, 4'd0, 32'd0, 32'd0, 1, 2'b01, 32'd12);
    idle(1);
    // alternating round robin
    do_reset(1);
    repeat (2) begin
      step(1, 4'd4, 32'd10, 32'd3, 1, 4'd7, 32'hF0, 32'h0F, 1, 2'b01, 32'd7);
      step(1, 4'd4, 32'd10, 32'd3, 1, 4'd7, 32'hF0, 32'h0F, 1, 2'b10, 32'hFF);
    end
    // backpressure then drain-and-refill
    step(1, 4'd4, 32'd10, 32'd3, 1, 4'd7, 32'hF0, 32'h0F, 1, 2'b01, 32'd7);
    repeat (3) begin
      step(1, 4'd4, 32'd10, 32'd3, 1, 4'd7, 32'hF0, 32'h0F, 0, 2'b00, 32'd0);
      chk("hold", {30'd0, rsp_valid, rsp_src, rsp_result}, {30'd0, 1'b1, 1'b0, 32'd7});
    end
    step(1, 4'd4, 32'd10, 32'd3, 1, 4'd7, 32'hF0, 32'h0F, 1, 2'b10, 32'hFF);
    idle(1);
    // illegal opcode
    step(0, 4'd0, 32'd0, 32'd0, 1, 4'd13, 32'hDEAD, 32'd0, 1, 2'b10, 32'd0);
    idle(1);
    chk("cnt_after_ill", {56'd0, grant_cnt0, grant_cnt1}, {56'd0, 4'd3, 4'd4});
    // saturation
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      chk("cnt0_sat", 64'(grant_cnt0), (i < 15) ? 64'(i) : 64'd15);
      step(1, 4'd3, 32'(i), 32'd1, 0, 4'd0, 32'd0, 32'd0, 1, 2'b01, 32'(i + 1));
    end
    chk("cnt_final", {56'd0, grant_cnt0, grant_cnt1}, {56'd0, 4'd15, 4'd0});
    idle(1);
    // reset with a pending response
    step(1, 4'd3, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, 1, 2'b01, 32'd2);
    chk("pending", 64'(rsp_valid), 64'd1);
    do_reset(0);
    #1;
    chk("rst2_rsp", {60'd0, rsp_valid, rsp_src, rsp_err, |rsp_result}, 64'd0);
    chk("rst2_cnt", {56'd0, grant_cnt0, grant_cnt1}, 64'd0);
    @(negedge clk);
    step(1, 4'd3, 32'd2, 32'd2, 1, 4'd7, 32'h1, 32'h3, 1, 2'b01, 32'd4);
    idle(1);
    idle(1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
